// File: rtl/clksw_sched.sv
// Clock-switch scheduler: decides when the CPU runs on the host (slow) clock
// or the fast clock, handshakes with the glitch-free switch and traps hung switches.
module clksw_sched #(
  parameter int                 DWELL_W   = 8,
  parameter logic [DWELL_W-1:0] DWELL_RST = 8'd32,
  parameter int                 TIMEOUT   = 1024
) (
  input  logic        hsclk_in,
  input  logic        rst_b,
  input  logic        host_req,
  input  logic        hsclk_selected,
  input  logic        lsclk_selected,
  input  logic        cfg_we,
  input  logic [15:0] cfg_wdata,
  output logic        hsclk_sel,
  output logic [1:0]  cpuclk_div_sel,
  output logic        cpu_rdy,
  output logic        sw_busy,
  output logic        sw_timeout
);

  localparam int              TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    LS_RUN,
    LS_HOLD,
    TO_HS,
    HS_RUN,
    TO_LS
  } state_t;

  state_t             state, state_d;
  logic               fb_hs_meta, fb_ls_meta, fb_hs, fb_ls;
  logic               turbo_en;
  logic [1:0]         div_pend;
  logic [DWELL_W-1:0] dwell, dwell_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               ls_wait, ls_wait_d;
  logic               ls_ok, hs_ok, turbo_eff, leave_fast, in_switch, timeout_hit, ls_next;
  logic               cfg_unused;

  assign cfg_unused = ^cfg_wdata[7:4];

  // Switch feedback is asynchronous to hsclk_in.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      fb_hs_meta <= 1'b0;
      fb_ls_meta <= 1'b0;
      fb_hs      <= 1'b0;
      fb_ls      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep the two flops a true shift chain.
      fb_hs_meta <= hsclk_selected;
      fb_ls_meta <= lsclk_selected;
      fb_hs      <= fb_hs_meta;
      fb_ls      <= fb_ls_meta;
    end
  end

  assign ls_ok = fb_ls & ~fb_hs;
  assign hs_ok = fb_hs & ~fb_ls;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d     = state;
    // A cfg write disabling turbo acts in the same cycle as host_req would.
    turbo_eff   = cfg_we ? cfg_wdata[0] : turbo_en;
    leave_fast  = host_req | ~turbo_eff;
    in_switch   = (state == TO_HS) || (state == TO_LS);
    timeout_hit = in_switch && (to_cnt == TO_LIMIT);
    case (state)
      LS_RUN:  if (turbo_en && !host_req) state_d = LS_HOLD;
      LS_HOLD: begin
        if (leave_fast)              state_d = LS_RUN;
        else if (dwell_cnt == '0)    state_d = TO_HS;
      end
      TO_HS: begin
        if (timeout_hit)             state_d = LS_RUN;
        else if (leave_fast)         state_d = TO_LS;
        else if (hs_ok)              state_d = HS_RUN;
      end
      HS_RUN:  if (leave_fast) state_d = TO_LS;
      TO_LS: begin
        if (timeout_hit || ls_ok)    state_d = LS_RUN;
      end
      default:                       state_d = LS_RUN;
    endcase
    ls_next   = (state_d == LS_RUN) || (state_d == LS_HOLD);
    // After a timeout the CPU stays stalled until the switch really reports LS.
    ls_wait_d = timeout_hit | (ls_wait & ~ls_ok);
  end

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      turbo_en   <= 1'b0;
      div_pend   <= 2'b00;
      dwell      <= DWELL_RST;
      sw_timeout <= 1'b0;
    end else begin
      if (timeout_hit) begin
        sw_timeout <= 1'b1;
        turbo_en   <= 1'b0;
      end else if (cfg_we) begin
        turbo_en <= cfg_wdata[0];
        if (cfg_wdata[3]) sw_timeout <= 1'b0;
      end
      if (cfg_we) begin
        div_pend <= cfg_wdata[2:1];
        dwell    <= DWELL_W'(cfg_wdata[15:8]);
      end
    end
  end

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state          <= LS_RUN;
      hsclk_sel      <= 1'b0;
      cpuclk_div_sel <= 2'b00;
      cpu_rdy        <= 1'b1;
      sw_busy        <= 1'b0;
      ls_wait        <= 1'b0;
      dwell_cnt      <= '0;
      to_cnt         <= '0;
    end else begin
      state     <= state_d;
      hsclk_sel <= (state_d == TO_HS) || (state_d == HS_RUN);
      sw_busy   <= (state_d == TO_HS) || (state_d == TO_LS);
      cpu_rdy   <= ~(host_req & (~ls_next | ls_wait_d));
      ls_wait   <= ls_wait_d;

      if (state_d == LS_HOLD && state != LS_HOLD)
        dwell_cnt <= dwell;
      else if (state == LS_HOLD && dwell_cnt != '0)
        dwell_cnt <= dwell_cnt - DWELL_W'(1);

      if (state_d != state && (state_d == TO_HS || state_d == TO_LS))
        to_cnt <= '0;
      else if (in_switch && to_cnt != TO_LIMIT)
        to_cnt <= to_cnt + TO_W'(1);

      // The divider only moves while the slow clock drives the CPU.
      if (state == LS_RUN || state == LS_HOLD)
        cpuclk_div_sel <= div_pend;
    end
  end

endmodule

// File: tb/tb_clksw_sched.sv
// Bench for clksw_sched: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a phase-level model of the scheduler.
module tb_clksw_sched;

  localparam int TMO = 16;

  logic        hsclk_in = 1'b0;
  logic        rst_b = 1'b0;
  logic        host_req = 1'b0;
  logic        hsclk_selected = 1'b0;
  logic        lsclk_selected = 1'b1;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_wdata = 16'h0000;
  logic        hsclk_sel, cpu_rdy, sw_busy, sw_timeout;
  logic [1:0]  cpuclk_div_sel;

  int total = 0;
  int bad = 0;

  clksw_sched #(.TIMEOUT(TMO)) dut (
    .hsclk_in       (hsclk_in),
    .rst_b          (rst_b),
    .host_req       (host_req),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .cfg_we         (cfg_we),
    .cfg_wdata      (cfg_wdata),
    .hsclk_sel      (hsclk_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .cpu_rdy        (cpu_rdy),
    .sw_busy        (sw_busy),
    .sw_timeout     (sw_timeout)
  );

  always #5 hsclk_in = ~hsclk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Phase-level model: slow (with a residency timer), going fast, fast, going slow.
  typedef enum {P_SLOW, P_UP, P_FAST, P_DOWN} phase_e;
  phase_e     ph;
  bit         holding;
  int         hold_age, hold_len, sw_age, m_dwell;
  bit         m_turbo, m_flag, m_stall;
  logic [1:0] m_pend, m_div;
  bit         m_fb1_hs, m_fb1_ls, m_fb2_hs, m_fb2_ls;
  bit         e_hs, e_rdy, e_busy;

  // Clock-switch environment model.
  bit sw_tgt, stuck_hs;
  int sw_cnt;
  int lat = 5;

  task automatic mdl_reset();
    ph = P_SLOW; holding = 0; hold_age = 0; hold_len = 0; sw_age = 0;
    m_dwell = 32; m_turbo = 0; m_flag = 0; m_stall = 0; m_pend = 2'b00; m_div = 2'b00;
    m_fb1_hs = 0; m_fb1_ls = 0; m_fb2_hs = 0; m_fb2_ls = 0;
    e_hs = 0; e_rdy = 1; e_busy = 0;
  endtask

  task automatic sw_reset();
    sw_tgt = 0; sw_cnt = 0; hsclk_selected = 1'b0; lsclk_selected = 1'b1;
  endtask

  task automatic mdl_step();
    bit turbo_now, want_slow, ls_seen, hs_seen, tmo;
    phase_e nph;
    turbo_now = cfg_we ? cfg_wdata[0] : m_turbo;
    want_slow = host_req || !turbo_now;
    ls_seen   = m_fb2_ls && !m_fb2_hs;
    hs_seen   = m_fb2_hs && !m_fb2_ls;
    tmo       = (ph == P_UP || ph == P_DOWN) && sw_age == TMO;
    if (ph == P_SLOW) m_div = m_pend;
    nph = ph;
    case (ph)
      P_SLOW: begin
        if (!holding) begin
          if (m_turbo && !host_req) begin
            holding = 1; hold_len = m_dwell; hold_age = 0;
          end
        end else if (want_slow) begin
          holding = 0;
        end else if (hold_age == hold_len) begin
          holding = 0; nph = P_UP;
        end else begin
          hold_age++;
        end
      end
      P_UP: begin
        if (tmo) nph = P_SLOW;
        else if (want_slow) nph = P_DOWN;
        else if (hs_seen) nph = P_FAST;
      end
      P_FAST: if (want_slow) nph = P_DOWN;
      P_DOWN: if (tmo || ls_seen) nph = P_SLOW;
    endcase
    if (nph != ph && (nph == P_UP || nph == P_DOWN)) sw_age = 0;
    else if (ph == P_UP || ph == P_DOWN) sw_age++;
    m_stall = tmo || (m_stall && !ls_seen);
    if (tmo) begin
      m_flag = 1; m_turbo = 0;
    end else if (cfg_we) begin
      m_turbo = cfg_wdata[0];
      if (cfg_wdata[3]) m_flag = 0;
    end
    if (cfg_we) begin
      m_pend = cfg_wdata[2:1]; m_dwell = int'(cfg_wdata[15:8]);
    end
    ph     = nph;
    e_hs   = (ph == P_UP || ph == P_FAST);
    e_busy = (ph == P_UP || ph == P_DOWN);
    e_rdy  = !(host_req && (ph != P_SLOW || m_stall));
    m_fb2_hs = m_fb1_hs; m_fb2_ls = m_fb1_ls;
    m_fb1_hs = hsclk_selected; m_fb1_ls = lsclk_selected;
  endtask

  // On a request change both feedbacks drop, then the new one asserts after lat cycles.
  task automatic sw_step();
    if (e_hs != sw_tgt) begin
      sw_tgt = e_hs; hsclk_selected = 1'b0; lsclk_selected = 1'b0; sw_cnt = lat;
    end else if (sw_cnt > 0) begin
      sw_cnt--;
      if (sw_cnt == 0 && !(sw_tgt && stuck_hs)) begin
        hsclk_selected = sw_tgt; lsclk_selected = !sw_tgt;
      end
    end
  endtask

  task automatic tick();
    mdl_step();
    @(posedge hsclk_in);
    #1;
    check("hsclk_sel", hsclk_sel, e_hs);
    check("cpu_rdy", cpu_rdy, e_rdy);
    check("sw_busy", sw_busy, e_busy);
    check("sw_timeout", sw_timeout, m_flag);
    check("cpuclk_div_sel", cpuclk_div_sel, m_div);
    sw_step();
  endtask

  task automatic cfg_write(input logic [15:0] d);
    cfg_we = 1'b1; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic sel, input logic busy);
    int n = 0;
    while ((hsclk_sel !== sel || sw_busy !== busy) && n < 200) begin
      tick(); n++;
    end
    check(tag, {hsclk_sel, sw_busy}, {sel, busy});
  endtask

  initial begin
    int  n;
    bit  rose;
    mdl_reset(); sw_reset(); stuck_hs = 0;
    #12;
    check("rst_hsclk_sel", hsclk_sel, 0);
    check("rst_div", cpuclk_div_sel, 0);
    check("rst_cpu_rdy", cpu_rdy, 1);
    check("rst_busy", sw_busy, 0);
    check("rst_timeout", sw_timeout, 0);
    rst_b = 1'b1;

    // turbo on, dwell 4: five cycles of hold, then the fast request.
    cfg_write(16'h0401);
    n = 0;
    while (!hsclk_sel && n < 40) begin tick(); n++; end
    check("hold_to_hs_cycles", n, 6);
    check("busy_in_to_hs", sw_busy, 1);
    wait_out("reach_hs_run", 1'b1, 1'b0);

    // host access from the fast clock.
    host_req = 1'b1;
    tick();
    check("req_drops_sel", hsclk_sel, 0);
    check("req_stalls", cpu_rdy, 0);
    n = 0;
    while (!lsclk_selected && n < 50) begin tick(); n++; end
    n = 0;
    while (!cpu_rdy && n < 10) begin tick(); n++; end
    check("rdy_after_ls", n, 3);
    host_req = 1'b0;
    wait_out("back_to_hs", 1'b1, 1'b0);

    // divider change while fast stays pending until slow.
    cfg_write(16'h0403);
    repeat (3) tick();
    check("div_held_in_hs", cpuclk_div_sel, 0);
    host_req = 1'b1;
    tick();
    wait_out("ls_for_div", 1'b0, 1'b0);
    check("div_at_ls_entry", cpuclk_div_sel, 0);
    tick();
    check("div_after_ls", cpuclk_div_sel, 1);
    host_req = 1'b0;

    // switch never confirms HS.
    stuck_hs = 1;
    wait_out("stuck_to_hs", 1'b1, 1'b1);
    n = 0;
    while (hsclk_sel && n < 100) begin n++; tick(); end
    check("to_hs_cycles", n, TMO + 1);
    check("timeout_set", sw_timeout, 1);
    rose = 0;
    repeat (30) begin tick(); if (hsclk_sel) rose = 1; end
    check("turbo_cleared", rose, 0);
    stuck_hs = 0;
    cfg_write(16'h0008);
    check("timeout_cleared", sw_timeout, 0);

    // abort during TO_HS.
    cfg_write(16'h0001);
    wait_out("abort_to_hs", 1'b1, 1'b1);
    host_req = 1'b1;
    tick();
    check("abort_sel", hsclk_sel, 0);
    check("abort_busy", sw_busy, 1);
    wait_out("abort_ls", 1'b0, 1'b0);
    host_req = 1'b0;

    // randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) host_req = ~host_req;
      if ($urandom_range(0, 60) == 0) lat = $urandom_range(1, 8);
      if ($urandom_range(0, 150) == 0) stuck_hs = ($urandom_range(0, 3) == 0);
      cfg_we = ($urandom_range(0, 40) == 0);
      cfg_wdata = {8'($urandom_range(0, 6)), 4'($urandom_range(0, 15)),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 5) != 0)};
      tick();
    end
    cfg_we = 1'b0; host_req = 1'b0; stuck_hs = 0; lat = 10;

    // asynchronous reset in the middle of TO_HS.
    cfg_write(16'h0009);
    wait_out("pre_rst_to_hs", 1'b1, 1'b1);
    #2 rst_b = 1'b0;
    #1;
    check("arst_hsclk_sel", hsclk_sel, 0);
    check("arst_div", cpuclk_div_sel, 0);
    check("arst_cpu_rdy", cpu_rdy, 1);
    check("arst_busy", sw_busy, 0);
    check("arst_timeout", sw_timeout, 0);
    mdl_reset(); sw_reset();
    #10 rst_b = 1'b1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
